// File: rtl/rvp_pkg.sv
// rvp_pkg: shared constants and state encoding for ready_valid_skid_proxy
package rvp_pkg;
    localparam int RVP_DATA_W = 28;
    localparam int RVP_CNT_W  = 32;

    typedef logic [1:0] rvp_state_t;

    localparam rvp_state_t EMPTY = 2'd0;
    localparam rvp_state_t BUSY  = 2'd1;
    localparam rvp_state_t FULL  = 2'd2;
endpackage

// File: rtl/rvp_xfer_counter.sv
// rvp_xfer_counter: saturating transfer counter, built only with RVP_XFER_COUNT_EN
module rvp_xfer_counter
    import rvp_pkg::*;
#(
    parameter int W = RVP_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) cnt <= '0;
        else cnt <= (en && !(&cnt)) ? cnt + 1'b1 : cnt;
endmodule

// File: rtl/ready_valid_skid_proxy.sv
// ready_valid_skid_proxy: two-entry skid buffer, all outputs decoded from flops.
// Optional RVP_XFER_COUNT_EN adds xfer_cnt and stall_flag outputs.
module ready_valid_skid_proxy
    import rvp_pkg::*;
#(
    parameter int DATA_W = RVP_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] up_data,
    input  logic              up_valid,
    output logic              up_ready,
    output logic [DATA_W-1:0] down_data,
    output logic              down_valid,
    input  logic              down_ready
`ifdef RVP_XFER_COUNT_EN
    ,
    output logic [RVP_CNT_W-1:0] xfer_cnt,
    output logic                 stall_flag
`endif
);
    rvp_state_t        state, state_d;
    logic [DATA_W-1:0] main_q, skid_q;
    logic              up_fire, dn_fire;

    assign up_ready   = state != FULL;
    assign down_valid = state != EMPTY;
    assign down_data  = main_q;
    assign up_fire    = up_valid & up_ready;
    assign dn_fire    = down_valid & down_ready;

    always_comb begin
        state_d = state;
        state_d = (state == EMPTY) ? (up_fire ? BUSY : EMPTY) :
                  (state == BUSY)  ? ((up_fire & !dn_fire) ? FULL :
                                      (!up_fire & dn_fire) ? EMPTY : BUSY) :
                                     (dn_fire ? BUSY : FULL);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_d;
            main_q <= (state == FULL) ? (dn_fire ? skid_q : main_q) :
                      (up_fire & (state == EMPTY | dn_fire)) ? up_data : main_q;
            skid_q <= (state == BUSY & up_fire & !dn_fire) ? up_data : skid_q;
        end

`ifdef RVP_XFER_COUNT_EN
    assign stall_flag = state == FULL;

    rvp_xfer_counter #(.W(RVP_CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (dn_fire),
        .cnt  (xfer_cnt)
    );
`endif
endmodule

// File: tb/tb_ready_valid_skid_proxy.sv
// tb_ready_valid_skid_proxy: directed and random traffic against a queue-based reference.
module tb_ready_valid_skid_proxy;
    localparam int W = 28;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] up_data = '0;
    logic         up_valid = 1'b0;
    logic         up_ready;
    logic [W-1:0] down_data;
    logic         down_valid;
    logic         down_ready = 1'b0;

    int           checks = 0;
    int           errors = 0;
    logic [W-1:0] q[$];
    logic [W-1:0] last_head = '0;
    int           nxt = 1;
    int           guard;

`ifdef RVP_XFER_COUNT_EN
    logic [31:0] xfer_cnt;
    logic        stall_flag;
    logic [31:0] cnt_m = '0;
`endif

    ready_valid_skid_proxy #(.DATA_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .up_data   (up_data),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .down_data (down_data),
        .down_valid(down_valid),
        .down_ready(down_ready)
`ifdef RVP_XFER_COUNT_EN
        ,
        .xfer_cnt  (xfer_cnt),
        .stall_flag(stall_flag)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        chk("down_valid", 32'(down_valid), 32'(q.size() > 0));
        chk("up_ready", 32'(up_ready), 32'(q.size() < 2));
        chk("down_data", 32'(down_data), 32'(q.size() > 0 ? q[0] : last_head));
`ifdef RVP_XFER_COUNT_EN
        chk("xfer_cnt", xfer_cnt, cnt_m);
        chk("stall_flag", 32'(stall_flag), 32'(q.size() == 2));
`endif
    endtask

    task automatic step(input logic uv, input logic dr);
        logic upf, dnf;
        @(negedge clk);
        up_valid   = uv;
        down_ready = dr;
        up_data    = uv ? W'(nxt) : W'($urandom);
        #1;
        check_outputs();
        @(posedge clk);
        upf = uv && q.size() < 2;
        dnf = dr && q.size() > 0;
        if (dnf) begin
            last_head = q.pop_front();
`ifdef RVP_XFER_COUNT_EN
            if (cnt_m != 32'hFFFF_FFFF) cnt_m++;
`endif
        end
        if (upf) begin
            q.push_back(W'(nxt));
            nxt++;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1);
    endtask

    initial begin
        #12;
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;

        nxt = 1;
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);
        drain();

        nxt = 11;
        guard = 0;
        while (nxt <= 20 && guard < 100) begin
            step(1'b1, guard[0]);
            guard++;
        end
        drain();

        nxt = 21;
        guard = 0;
        while (nxt <= 30 && guard < 100) begin
            step(guard[0], 1'b1);
            guard++;
        end
        drain();

        nxt = 31;
        guard = 0;
        while (nxt <= 40 && guard < 100) begin
            step(guard[0], guard[0]);
            guard++;
        end
        guard = 0;
        while (nxt <= 50 && guard < 100) begin
            step(guard[0], !guard[0]);
            guard++;
        end
        drain();

        nxt = 51;
        guard = 0;
        while (nxt <= 255 && guard < 2000) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            guard++;
        end
        drain();

        nxt = 100;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        @(negedge clk);
        up_valid = 1'b0;
        #1;
        check_outputs();
        #1;
        rst_n = 1'b0;
        #1;
        q.delete();
        last_head = '0;
`ifdef RVP_XFER_COUNT_EN
        cnt_m = '0;
`endif
        chk("rst_down_valid", 32'(down_valid), 32'd0);
        chk("rst_up_ready", 32'(up_ready), 32'd1);
        chk("rst_down_data", 32'(down_data), 32'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        nxt = 102;
        step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
